// File: rtl/ssp_tx_fifo_param.sv
// SSP transmit FIFO: buffers APB writes and hands words to the SSP shifter on SENT.
// Latency: TxDATA is registered and updates one PCLK edge after a SENT that pops a word.
// Backpressure: writes while full are dropped (SSPTXINTR high); SENT while empty is ignored.
// Optional: define SSP_TXFIFO_OVERRUN_EN to build the sticky OVERRUN flag (cleared by OVR_CLR).
module ssp_tx_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  localparam int AW       = $clog2(DEPTH),
  localparam int LW       = AW + 1
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic              PSEL,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic              SENT,
  input  logic              OVR_CLR,
  output logic [DATA_W-1:0] TxDATA,
  output logic              VALID,
  output logic              SSPTXINTR,
  output logic              ALMOST_FULL,
  output logic [LW-1:0]     LEVEL,
  output logic              OVERRUN
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              wr_req, full, not_empty, wre, rde;

  assign wr_req    = PSEL & PWRITE;
  assign full      = (level_q == LW'(DEPTH));
  assign not_empty = (level_q != '0);
  // Enables use the pre-edge full/empty state, so a full FIFO drops a
  // same-cycle write and an empty FIFO ignores a same-cycle SENT.
  assign wre       = wr_req & ~full;
  assign rde       = SENT & not_empty;

  assign TxDATA      = tx_q;
  assign VALID       = not_empty;
  assign SSPTXINTR   = full;
  assign ALMOST_FULL = (level_q >= LW'(AF_THRESH));
  assign LEVEL       = level_q;

  // Next-state for pointers, occupancy and output word; pointers wrap by natural overflow.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    tx_d    = tx_q;
    if (wre) wp_d = wp_q + AW'(1);
    if (rde) begin
      rp_d = rp_q + AW'(1);
      tx_d = mem_q[rp_q];
    end
    case ({wre, rde})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state register; storage array is deliberately left out of reset.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      tx_q    <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      tx_q    <= tx_d;
    end
  end

  // Storage write port.
  always_ff @(posedge PCLK) begin
    if (wre) mem_q[wp_q] <= PWDATA;
  end

`ifdef SSP_TXFIFO_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Sticky overrun: a write attempt while full sets it and takes priority over OVR_CLR.
  always_comb begin
    ovr_d = ovr_q;
    if (wr_req & full)  ovr_d = 1'b1;
    else if (OVR_CLR)   ovr_d = 1'b0;
  end

  // Overrun flag register.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) ovr_q <= 1'b0;
    else          ovr_q <= ovr_d;
  end

  assign OVERRUN = ovr_q;
`else
  logic ovr_clr_unused;
  assign ovr_clr_unused = OVR_CLR;
  assign OVERRUN        = 1'b0;
`endif

endmodule
